// File: rtl/ccr_controller_pkg.sv
// Shared definitions for the condition-code register controller:
// ALU op codes, jump encodings and CCR bit positions.
package ccr_controller_pkg;

  // ALU control codes (same encoding as the ALU controlSignal)
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SETC = 4'd11;
  localparam logic [3:0] OP_CLRC = 4'd12;

  // Conditional jump kinds
  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_JZ   = 2'd1,
    JMP_JN   = 2'd2,
    JMP_JC   = 2'd3
  } jmp_e;

  // CCR layout {C,N,Z}
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int Z_BIT = 0;

  // True for ops whose raw ALU flags overwrite all three CCR bits
  function automatic logic updates_all_flags(input logic [3:0] op);
    case (op)
      OP_NOT, OP_INC, OP_DEC, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_SHL, OP_SHR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ccr_lifo.sv
// Small LIFO that saves CCR snapshots across nested interrupts.
// Overflowing pushes and underflowing pops are ignored here; the
// controller turns them into sticky error flags.
module ccr_lifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] sp_reg;
  logic [2:0]     entry [DEPTH];
  logic [IW-1:0]  rd_idx;

  assign full   = (sp_reg == SPW'(DEPTH));
  assign empty  = (sp_reg == '0);
  // Top of stack; meaningless while empty, the controller never uses it then
  assign rd_idx = IW'(sp_reg - SPW'(1));
  assign dout   = entry[rd_idx];

  // Stack pointer: grows on accepted push, shrinks on accepted pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SPW'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SPW'(1);
    end
  end

  // One 3-bit slot per nesting level; contents need no reset
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [2:0] slot_reg;

    // Capture din into the slot the stack pointer currently addresses
    always_ff @(posedge clk) begin
      if (push && !full && (sp_reg == SPW'(gi))) begin
        slot_reg <= din;
      end
    end

    assign entry[gi] = slot_reg;
  end

endmodule

// File: rtl/ccr_controller.sv
// Condition-code register controller for the execute stage: flag
// masking per ALU op, SETC/CLRC, conditional jump evaluation with
// flag clear on taken jumps, and CCR save/restore for interrupts.
module ccr_controller
  import ccr_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  logic       valid_ex,
  input  logic [3:0] alu_op,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic [1:0] jmp_type,
  input  logic       int_save,
  input  logic       int_restore,
  output logic [2:0] ccr,
  output logic       carry_in,
  output logic       take_branch,
  output logic       stack_ovf,
  output logic       stack_unf,
  output logic       proto_err
);

  logic       act;
  logic [2:0] ccr_reg;
  logic [2:0] masked;
  logic [2:0] ccr_next;
  logic       do_restore;
  logic       do_save;
  logic       push;
  logic       pop;
  logic [2:0] lifo_dout;
  logic       lifo_full;
  logic       lifo_empty;
  logic       ovf_reg;
  logic       unf_reg;
  logic       proto_reg;

  assign act        = en & valid_ex & ~flush;
  // Restore outranks save; a simultaneous save is dropped
  assign do_restore = en & int_restore;
  assign do_save    = en & int_save & ~int_restore;
  assign push       = do_save & ~lifo_full;
  assign pop        = do_restore & ~lifo_empty;

  // Apply the per-op flag mask to the raw ALU flags
  always_comb begin
    masked = ccr_reg;
    if (act) begin
      if (updates_all_flags(alu_op)) begin
        masked[C_BIT] = alu_c;
        masked[N_BIT] = alu_n;
        masked[Z_BIT] = alu_z;
      end else if (alu_op == OP_SETC) begin
        masked[C_BIT] = 1'b1;
      end else if (alu_op == OP_CLRC) begin
        masked[C_BIT] = 1'b0;
      end
    end
  end

  // Jump decision straight from the registered flags
  always_comb begin
    take_branch = act & (((jmp_type == JMP_JZ) & ccr_reg[Z_BIT]) |
                         ((jmp_type == JMP_JN) & ccr_reg[N_BIT]) |
                         ((jmp_type == JMP_JC) & ccr_reg[C_BIT]));
  end

  // A taken jump clears its tested flag, overriding any ALU update
  always_comb begin
    ccr_next = masked;
    if (take_branch) begin
      case (jmp_type)
        JMP_JZ:  ccr_next[Z_BIT] = 1'b0;
        JMP_JN:  ccr_next[N_BIT] = 1'b0;
        JMP_JC:  ccr_next[C_BIT] = 1'b0;
        default: ccr_next = masked;
      endcase
    end
  end

  ccr_lifo #(
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ccr_next),
    .dout  (lifo_dout),
    .full  (lifo_full),
    .empty (lifo_empty)
  );

  // CCR register: a successful pop replaces this cycle's update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_reg <= 3'b000;
    end else if (en) begin
      ccr_reg <= pop ? lifo_dout : ccr_next;
    end
  end

  // Sticky protocol and stack errors, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      proto_reg <= 1'b0;
    end else begin
      if (do_save && lifo_full)                  ovf_reg   <= 1'b1;
      if (do_restore && lifo_empty)              unf_reg   <= 1'b1;
      if (en && int_save && int_restore)         proto_reg <= 1'b1;
    end
  end

  assign ccr       = ccr_reg;
  assign carry_in  = ccr_reg[C_BIT];
  assign stack_ovf = ovf_reg;
  assign stack_unf = unf_reg;
  assign proto_err = proto_reg;

endmodule

// File: tb/tb_ccr_controller.sv
// Self-checking bench for ccr_controller: directed vector table,
// an asynchronous-reset sequence, then randomized cycles checked
// against a queue-based reference model.
module tb_ccr_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, flush, valid_ex;
  logic [3:0] alu_op;
  logic       alu_c, alu_z, alu_n;
  logic [1:0] jmp_type;
  logic       int_save, int_restore;
  logic [2:0] ccr;
  logic       carry_in, take_branch, stack_ovf, stack_unf, proto_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ccr_controller #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .flush       (flush),
    .valid_ex    (valid_ex),
    .alu_op      (alu_op),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .jmp_type    (jmp_type),
    .int_save    (int_save),
    .int_restore (int_restore),
    .ccr         (ccr),
    .carry_in    (carry_in),
    .take_branch (take_branch),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf),
    .proto_err   (proto_err)
  );

  typedef struct {
    bit       en, valid, flush;
    bit [3:0] op;
    bit       c, z, n;
    bit [1:0] jt;
    bit       sv, rs;
  } in_t;

  typedef struct {
    in_t      i;
    bit       tb;
    bit [2:0] ccr;
    bit       ovf, unf, pe;
  } vec_t;

  // ---------------- reference model ----------------
  bit [2:0] m_ccr;
  bit       m_ovf, m_unf, m_pe;
  bit [2:0] m_stack[$];
  localparam int MDEPTH = 4;

  function automatic void model_reset();
    m_ccr = 3'b000; m_ovf = 0; m_unf = 0; m_pe = 0;
    m_stack.delete();
  endfunction

  function automatic bit model_branch(in_t i);
    bit act = i.en && i.valid && !i.flush;
    return act && ((i.jt == 2'd1 && m_ccr[0]) ||
                   (i.jt == 2'd2 && m_ccr[1]) ||
                   (i.jt == 2'd3 && m_ccr[2]));
  endfunction

  function automatic void model_edge(in_t i);
    bit       act = i.en && i.valid && !i.flush;
    bit       br  = model_branch(i);
    bit [2:0] nxt = m_ccr;
    if (!i.en) return;
    if (act) begin
      if (i.op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10})
        nxt = {i.c, i.n, i.z};
      else if (i.op == 4'd11) nxt[2] = 1'b1;
      else if (i.op == 4'd12) nxt[2] = 1'b0;
    end
    if (br) begin
      if (i.jt == 2'd1) nxt[0] = 1'b0;
      if (i.jt == 2'd2) nxt[1] = 1'b0;
      if (i.jt == 2'd3) nxt[2] = 1'b0;
    end
    if (i.rs) begin
      if (i.sv) m_pe = 1;
      if (m_stack.size() == 0) begin
        m_unf = 1;
        m_ccr = nxt;
      end else begin
        m_ccr = m_stack.pop_back();
      end
    end else if (i.sv) begin
      if (m_stack.size() == MDEPTH) m_ovf = 1;
      else m_stack.push_back(nxt);
      m_ccr = nxt;
    end else begin
      m_ccr = nxt;
    end
  endfunction

  // ---------------- helpers ----------------
  function automatic in_t mk_in(bit e, bit v, bit f, bit [3:0] op, bit c, bit z,
                                bit n, bit [1:0] jt, bit sv, bit rs);
    in_t i;
    i.en = e; i.valid = v; i.flush = f; i.op = op;
    i.c = c; i.z = z; i.n = n; i.jt = jt; i.sv = sv; i.rs = rs;
    return i;
  endfunction

  function automatic vec_t mk(bit e, bit v, bit f, bit [3:0] op, bit c, bit z,
                              bit n, bit [1:0] jt, bit sv, bit rs,
                              bit tb, bit [2:0] cc, bit ovf, bit unf, bit pe);
    vec_t r;
    r.i = mk_in(e, v, f, op, c, z, n, jt, sv, rs);
    r.tb = tb; r.ccr = cc; r.ovf = ovf; r.unf = unf; r.pe = pe;
    return r;
  endfunction

  task automatic check(string name, logic [6:0] got, logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(in_t i);
    en = i.en; valid_ex = i.valid; flush = i.flush; alu_op = i.op;
    alu_c = i.c; alu_z = i.z; alu_n = i.n; jmp_type = i.jt;
    int_save = i.sv; int_restore = i.rs;
  endtask

  function automatic logic [6:0] dut_state();
    return {ccr, carry_in, stack_ovf, stack_unf, proto_err};
  endfunction

  // Starts 1 time unit after a rising edge, ends at the same point of the next cycle
  task automatic run_cycle(in_t i, output logic tb_got, output bit tb_exp,
                           output logic [6:0] st_got, output logic [6:0] st_exp);
    drive(i);
    #2;
    tb_got = take_branch;
    tb_exp = model_branch(i);
    @(posedge clk);
    model_edge(i);
    #1;
    st_got = dut_state();
    st_exp = {m_ccr, m_ccr[2], m_ovf, m_unf, m_pe};
  endtask

  vec_t tbl[$];

  initial begin
    logic       tbg;
    bit         tbe;
    logic [6:0] sg, se;
    in_t        idle;

    idle = mk_in(1, 0, 0, 4'd0, 0, 0, 0, 2'd0, 0, 0);
    drive(idle);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_state(), 7'b000_0_000);
    rst_n = 1'b1;

    //        en v f op     c z n jt sv rs   tb ccr     ovf unf pe
    tbl.push_back(mk(1,1,0,4'd5, 1,0,1,2'd0,0,0, 0,3'b110, 0,0,0)); // ADD
    tbl.push_back(mk(1,1,0,4'd4, 0,1,0,2'd0,0,0, 0,3'b110, 0,0,0)); // MOV no change
    tbl.push_back(mk(1,1,0,4'd5, 0,1,0,2'd0,0,0, 0,3'b001, 0,0,0)); // Z only
    tbl.push_back(mk(1,1,1,4'd0, 0,0,0,2'd1,0,0, 0,3'b001, 0,0,0)); // JZ flushed
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd1,0,0, 1,3'b000, 0,0,0)); // JZ taken
    tbl.push_back(mk(1,1,0,4'd11,0,1,0,2'd0,0,0, 0,3'b100, 0,0,0)); // SETC
    tbl.push_back(mk(1,1,0,4'd12,0,1,1,2'd0,0,0, 0,3'b000, 0,0,0)); // CLRC
    tbl.push_back(mk(1,1,0,4'd5, 0,1,0,2'd0,1,0, 0,3'b001, 0,0,0)); // push 1
    tbl.push_back(mk(1,1,0,4'd5, 0,0,1,2'd0,1,0, 0,3'b010, 0,0,0)); // push 2
    tbl.push_back(mk(1,1,0,4'd5, 0,1,1,2'd0,1,0, 0,3'b011, 0,0,0)); // push 3
    tbl.push_back(mk(1,1,0,4'd5, 1,0,0,2'd0,1,0, 0,3'b100, 0,0,0)); // push 4
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd0,1,0, 0,3'b100, 1,0,0)); // overflow
    tbl.push_back(mk(1,1,0,4'd5, 1,1,1,2'd0,0,1, 0,3'b100, 1,0,0)); // pop 4
    tbl.push_back(mk(1,1,0,4'd5, 1,1,1,2'd0,0,1, 0,3'b011, 1,0,0)); // pop 3
    tbl.push_back(mk(1,1,0,4'd5, 1,1,1,2'd0,0,1, 0,3'b010, 1,0,0)); // pop 2
    tbl.push_back(mk(1,1,0,4'd5, 1,1,1,2'd0,0,1, 0,3'b001, 1,0,0)); // pop 1
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd0,0,1, 0,3'b001, 1,1,0)); // underflow
    tbl.push_back(mk(1,1,0,4'd11,0,0,0,2'd0,1,0, 0,3'b101, 1,1,0)); // SETC + push
    tbl.push_back(mk(0,1,0,4'd5, 1,1,1,2'd1,1,0, 0,3'b101, 1,1,0)); // stall
    tbl.push_back(mk(0,1,0,4'd5, 1,1,1,2'd3,1,0, 0,3'b101, 1,1,0)); // stall
    tbl.push_back(mk(0,1,0,4'd5, 1,1,1,2'd2,1,0, 0,3'b101, 1,1,0)); // stall
    tbl.push_back(mk(1,1,0,4'd12,0,0,0,2'd0,1,1, 0,3'b101, 1,1,1)); // save+restore
    tbl.push_back(mk(1,1,0,4'd5, 0,0,0,2'd0,0,0, 0,3'b000, 1,1,1));
    tbl.push_back(mk(1,1,0,4'd5, 1,0,1,2'd0,0,0, 0,3'b110, 1,1,1));
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd3,0,0, 1,3'b010, 1,1,1)); // JC taken
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd2,0,0, 1,3'b000, 1,1,1)); // JN taken
    tbl.push_back(mk(1,1,0,4'd0, 0,0,0,2'd3,0,0, 0,3'b000, 1,1,1)); // JC not taken

    foreach (tbl[k]) begin
      run_cycle(tbl[k].i, tbg, tbe, sg, se);
      check($sformatf("table%0d_branch", k), {6'b0, tbg}, {6'b0, tbl[k].tb});
      check($sformatf("table%0d_state", k), sg,
            {tbl[k].ccr, tbl[k].ccr[2], tbl[k].ovf, tbl[k].unf, tbl[k].pe});
    end

    // Two pushes of 3'b111 (sp=2), then asynchronous reset mid-cycle
    run_cycle(mk_in(1,1,0,4'd5,1,1,1,2'd0,1,0), tbg, tbe, sg, se);
    check("async_pre_push1", sg, se);
    run_cycle(mk_in(1,1,0,4'd5,1,1,1,2'd0,1,0), tbg, tbe, sg, se);
    check("async_pre_push2", sg, {3'b111, 1'b1, 3'b111});
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", dut_state(), 7'b000_0_000);
    model_reset();
    @(posedge clk);
    #1;
    check("async_reset_held", dut_state(), 7'b000_0_000);
    rst_n = 1'b1;
    // Stack pointer must be back at zero: the first pop underflows
    run_cycle(mk_in(1,1,0,4'd0,0,0,0,2'd0,0,1), tbg, tbe, sg, se);
    check("post_reset_pop_empty", sg, 7'b000_0_010);

    // Randomized cycles against the reference model
    for (int k = 0; k < 400; k++) begin
      in_t r;
      r.en    = ($urandom_range(0, 9) != 0);
      r.valid = ($urandom_range(0, 7) != 0);
      r.flush = ($urandom_range(0, 5) == 0);
      r.op    = 4'($urandom_range(0, 15));
      r.c     = 1'($urandom);
      r.z     = 1'($urandom);
      r.n     = 1'($urandom);
      r.jt    = 2'($urandom);
      r.sv    = ($urandom_range(0, 4) == 0);
      r.rs    = ($urandom_range(0, 4) == 0);
      run_cycle(r, tbg, tbe, sg, se);
      check($sformatf("rand%0d_branch", k), {6'b0, tbg}, {6'b0, tbe});
      check($sformatf("rand%0d_state", k), sg, se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
